// File: rtl/g2x_rx_arb.sv
// Two-source receive arbiter: reads a byte count per frame, then streams that frame's
// data words into one merged output with sof/eof/lbytes framing and an inter-frame gap.
module g2x_rx_arb #(
  parameter logic [15:0] MAX_BCNT   = 16'd9600,
  parameter int unsigned IFG_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic [1:0]  src_en,
  input  logic [1:0]  bcnt_empty,
  input  logic [15:0] bcnt_in0,
  input  logic [15:0] bcnt_in1,
  input  logic [63:0] data_in0,
  input  logic [63:0] data_in1,
  input  logic [7:0]  ctrl_in0,
  input  logic [7:0]  ctrl_in1,
  output logic [1:0]  bcnt_re,
  output logic [1:0]  data_re,
  output logic [63:0] data_out,
  output logic [7:0]  ctrl_out,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic [2:0]  out_lbytes,
  output logic        out_src,
  output logic        bcnt_err
);

  localparam logic [3:0] GapLen = (IFG_CYCLES == 0) ? 4'd1 : 4'(IFG_CYCLES);

  typedef enum logic [1:0] {StIdle, StBcnt, StXfer, StGap} state_e;

  state_e      state_q;
  logic        grant_q;
  logic        last_q;
  logic        wait_q;
  logic [13:0] cnt_q;
  logic        first_q;
  logic        drop_q;
  logic [2:0]  lbytes_q;
  logic [3:0]  gap_q;

  // Tags for the word whose FIFO read data arrives this cycle.
  logic        s1_keep_q;
  logic        s1_sof_q;
  logic        s1_eof_q;
  logic [2:0]  s1_lbytes_q;
  logic        s1_src_q;

  logic [1:0]  elig;
  logic        gnt;
  logic [15:0] bcnt_sel;
  logic [13:0] words;

  always_comb begin
    elig     = src_en & ~bcnt_empty;
    gnt      = (&elig) ? ~last_q : elig[1];
    bcnt_sel = grant_q ? bcnt_in1 : bcnt_in0;
    words    = 14'(({1'b0, bcnt_sel} + 17'd7) >> 3);
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      wait_q   <= 1'b0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      drop_q   <= 1'b0;
      lbytes_q <= '0;
      gap_q    <= '0;
      bcnt_re  <= '0;
      data_re  <= '0;
      bcnt_err <= 1'b0;
    end else begin
      bcnt_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|elig) begin
            grant_q <= gnt;
            last_q  <= gnt;
            bcnt_re <= gnt ? 2'b10 : 2'b01;
            wait_q  <= 1'b1;
            state_q <= StBcnt;
          end
        end
        StBcnt: begin
          // First BCNT cycle carries the read strobe; the count is valid on the second.
          if (wait_q) begin
            bcnt_re <= '0;
            wait_q  <= 1'b0;
          end else begin
            lbytes_q <= bcnt_sel[2:0];
            cnt_q    <= words;
            first_q  <= 1'b1;
            if (bcnt_sel == 16'd0) begin
              bcnt_err <= 1'b1;
              gap_q    <= GapLen;
              state_q  <= StGap;
            end else begin
              bcnt_err <= (bcnt_sel > MAX_BCNT);
              drop_q   <= (bcnt_sel > MAX_BCNT);
              data_re  <= grant_q ? 2'b10 : 2'b01;
              state_q  <= StXfer;
            end
          end
        end
        StXfer: begin
          first_q <= 1'b0;
          cnt_q   <= cnt_q - 14'd1;
          if (cnt_q == 14'd1) begin
            data_re <= '0;
            gap_q   <= GapLen;
            state_q <= StGap;
          end
        end
        StGap: begin
          gap_q <= gap_q - 4'd1;
          if (gap_q == 4'd1) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      s1_keep_q   <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
      s1_lbytes_q <= '0;
      s1_src_q    <= 1'b0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_lbytes  <= '0;
      out_src     <= 1'b0;
      data_out    <= '0;
      ctrl_out    <= '0;
    end else begin
      s1_keep_q   <= (state_q == StXfer) && !drop_q;
      s1_sof_q    <= first_q;
      s1_eof_q    <= (cnt_q == 14'd1);
      s1_lbytes_q <= lbytes_q;
      s1_src_q    <= grant_q;
      out_valid   <= s1_keep_q;
      out_sof     <= s1_keep_q && s1_sof_q;
      out_eof     <= s1_keep_q && s1_eof_q;
      out_lbytes  <= (s1_keep_q && s1_eof_q) ? s1_lbytes_q : 3'd0;
      if (s1_keep_q) begin
        data_out <= s1_src_q ? data_in1 : data_in0;
        ctrl_out <= s1_src_q ? ctrl_in1 : ctrl_in0;
        out_src  <= s1_src_q;
      end
    end
  end

endmodule

// File: tb/tb_g2x_rx_arb.sv
// Directed bench for g2x_rx_arb: FIFO models per source, an output monitor and an
// expected-word list filled by hand-specified frame pushes.
module tb_g2x_rx_arb;

  logic        clk = 1'b0;
  logic        reset_;
  logic [1:0]  src_en;
  logic [1:0]  bcnt_empty;
  logic [15:0] bcnt_rd [2] = '{16'd0, 16'd0};
  logic [63:0] data_rd [2] = '{64'd0, 64'd0};
  logic [7:0]  ctrl_rd [2] = '{8'd0, 8'd0};
  logic [1:0]  bcnt_re;
  logic [1:0]  data_re;
  logic [63:0] data_out;
  logic [7:0]  ctrl_out;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic [2:0]  out_lbytes;
  logic        out_src;
  logic        bcnt_err;

  always #5 clk = ~clk;

  g2x_rx_arb dut (
    .clk        (clk),
    .reset_     (reset_),
    .src_en     (src_en),
    .bcnt_empty (bcnt_empty),
    .bcnt_in0   (bcnt_rd[0]),
    .bcnt_in1   (bcnt_rd[1]),
    .data_in0   (data_rd[0]),
    .data_in1   (data_rd[1]),
    .ctrl_in0   (ctrl_rd[0]),
    .ctrl_in1   (ctrl_rd[1]),
    .bcnt_re    (bcnt_re),
    .data_re    (data_re),
    .data_out   (data_out),
    .ctrl_out   (ctrl_out),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_lbytes (out_lbytes),
    .out_src    (out_src),
    .bcnt_err   (bcnt_err)
  );

  // FIFO models: write pointers owned by the stimulus, read pointers by the pop process.
  logic [15:0] bmem [2][64];
  logic [71:0] dmem [2][4096];
  int bwp [2];
  int brp [2];
  int dwp [2];
  int drp [2];

  assign bcnt_empty[0] = (bwp[0] == brp[0]);
  assign bcnt_empty[1] = (bwp[1] == brp[1]);

  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (bcnt_re[n] && brp[n] != bwp[n]) begin
        bcnt_rd[n] <= bmem[n][brp[n]];
        brp[n]     <= brp[n] + 1;
      end
      if (data_re[n] && drp[n] != dwp[n]) begin
        {ctrl_rd[n], data_rd[n]} <= dmem[n][drp[n]];
        drp[n] <= drp[n] + 1;
      end
    end
  end

  // Output monitor.
  logic [77:0] got_w [$];
  int          got_cyc [$];
  int          dre_rise [$];
  int          cyc;
  int          dre_cnt [2];
  int          err_cnt;
  int          viol;
  logic [1:0]  prev_dre;

  initial begin
    cyc = 0; err_cnt = 0; viol = 0; prev_dre = 2'b00;
    dre_cnt[0] = 0; dre_cnt[1] = 0;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (out_valid) begin
      got_w.push_back({data_out, ctrl_out, out_sof, out_eof, out_lbytes, out_src});
      got_cyc.push_back(cyc);
    end
    if (data_re != 2'b00 && prev_dre == 2'b00) dre_rise.push_back(cyc);
    prev_dre   = data_re;
    dre_cnt[0] = dre_cnt[0] + int'(data_re[0]);
    dre_cnt[1] = dre_cnt[1] + int'(data_re[1]);
    err_cnt    = err_cnt + int'(bcnt_err);
    if (bcnt_re == 2'b11 || data_re == 2'b11 || (|bcnt_re && |data_re) ||
        (!out_valid && (out_sof || out_eof || out_lbytes != 3'd0)))
      viol = viol + 1;
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [77:0] exp_w [$];
  int          seq = 0;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push_frame(input int src, input logic [15:0] bcnt, input int nw,
                            input logic [2:0] lb, input bit expect_out);
    logic [63:0] d;
    logic [7:0]  c;
    bmem[src][bwp[src]] = bcnt;
    bwp[src]++;
    for (int i = 0; i < nw; i++) begin
      seq++;
      d = {(src != 0) ? 32'h5111_0000 : 32'h5000_0000, 32'(seq)};
      c = 8'(seq * 3);
      dmem[src][dwp[src]] = {c, d};
      dwp[src]++;
      if (expect_out)
        exp_w.push_back({d, c, (i == 0), (i == nw - 1), (i == nw - 1) ? lb : 3'd0, 1'(src)});
    end
  endtask

  function automatic int gc(input int i);
    return (i < got_cyc.size()) ? got_cyc[i] : -1000;
  endfunction

  task automatic cmp_words(input string tag, input int gb, input int eb);
    check_eq({tag, " word count"}, 80'(got_w.size() - gb), 80'(exp_w.size() - eb));
    for (int i = 0; gb + i < got_w.size() && eb + i < exp_w.size(); i++)
      check_eq($sformatf("%s word %0d", tag, i), 80'(got_w[gb + i]), 80'(exp_w[eb + i]));
  endtask

  task automatic wait_dre(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (data_re[n]) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_ = 1'b1;
    run(2);
    for (int n = 0; n < 2; n++) begin
      bwp[n] = brp[n];
      dwp[n] = drp[n];
    end
    @(negedge clk);
    reset_ = 1'b0;
  endtask

  initial begin
    int gb, eb, r0, d0, d1, e0;
    bit ok;
    reset_ = 1'b1;
    src_en = 2'b00;
    run(3);
    check_eq("reset ctl", 80'({bcnt_re, data_re, out_valid, out_sof, out_eof, out_lbytes,
                              out_src, bcnt_err}), 80'd0);
    check_eq("reset data", 80'({ctrl_out, data_out}), 80'd0);
    @(negedge clk);
    reset_ = 1'b0;

    // 64-byte frame on source 0.
    gb = got_w.size(); eb = exp_w.size(); r0 = dre_rise.size();
    d0 = dre_cnt[0]; d1 = dre_cnt[1];
    push_frame(0, 16'd64, 8, 3'd0, 1'b1);
    src_en = 2'b01;
    run(40);
    src_en = 2'b00;
    cmp_words("t1", gb, eb);
    check_eq("t1 dre0 cycles", 80'(dre_cnt[0] - d0), 80'd8);
    check_eq("t1 dre1 cycles", 80'(dre_cnt[1] - d1), 80'd0);
    check_eq("t1 read-to-out latency",
             80'(gc(gb) - ((r0 < dre_rise.size()) ? dre_rise[r0] : 0)), 80'd2);
    check_eq("t1 out burst span", 80'(gc(gb + 7) - gc(gb)), 80'd7);

    // Both sources pending after reset: 0, then 1, then 0 again.
    do_reset();
    gb = got_w.size(); eb = exp_w.size();
    push_frame(0, 16'd9, 2, 3'd1, 1'b1);
    push_frame(1, 16'd17, 3, 3'd1, 1'b1);
    push_frame(0, 16'd8, 1, 3'd0, 1'b1);
    src_en = 2'b11;
    run(60);
    src_en = 2'b00;
    cmp_words("t2", gb, eb);
    // Last word to next first word: read latency plus IFG, arbitration and count fetch.
    check_eq("t2 inter-frame spacing", 80'(gc(gb + 2) - gc(gb + 1)), 80'd6);

    // Zero byte count on source 1, then a legal frame.
    gb = got_w.size(); eb = exp_w.size(); e0 = err_cnt; d1 = dre_cnt[1];
    push_frame(1, 16'd0, 0, 3'd0, 1'b1);
    push_frame(1, 16'd24, 3, 3'd0, 1'b1);
    src_en = 2'b10;
    run(40);
    src_en = 2'b00;
    check_eq("t3 err pulses", 80'(err_cnt - e0), 80'd1);
    check_eq("t3 dre1 cycles", 80'(dre_cnt[1] - d1), 80'd3);
    cmp_words("t3", gb, eb);

    // Oversize frame is drained silently, following frame stays aligned.
    gb = got_w.size(); eb = exp_w.size(); e0 = err_cnt; d0 = dre_cnt[0];
    push_frame(0, 16'd9601, 1201, 3'd1, 1'b0);
    push_frame(0, 16'd13, 2, 3'd5, 1'b1);
    src_en = 2'b01;
    run(1300);
    src_en = 2'b00;
    check_eq("t4 err pulses", 80'(err_cnt - e0), 80'd1);
    check_eq("t4 dre0 cycles", 80'(dre_cnt[0] - d0), 80'd1203);
    cmp_words("t4", gb, eb);

    // Enable dropped mid-frame: frame completes, next one waits.
    gb = got_w.size(); eb = exp_w.size(); d0 = dre_cnt[0];
    push_frame(0, 16'd60, 8, 3'd4, 1'b1);
    push_frame(0, 16'd16, 2, 3'd0, 1'b0);
    src_en = 2'b01;
    wait_dre(0, ok);
    check_eq("t5 frame start", 80'(ok), 80'd1);
    run(2);
    src_en = 2'b00;
    run(40);
    cmp_words("t5", gb, eb);
    check_eq("t5 dre0 cycles", 80'(dre_cnt[0] - d0), 80'd8);
    check_eq("t5 src0 still pending", 80'(bcnt_empty[0]), 80'd0);

    // Reset on the third data read of an 8-word frame.
    do_reset();
    push_frame(0, 16'd64, 8, 3'd0, 1'b0);
    src_en = 2'b01;
    wait_dre(0, ok);
    check_eq("t6 frame start", 80'(ok), 80'd1);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_ = 1'b1;
    #1;
    check_eq("t6 reset ctl", 80'({bcnt_re, data_re, out_valid, out_sof, out_eof, out_lbytes,
                                 out_src, bcnt_err}), 80'd0);
    check_eq("t6 reset data", 80'({ctrl_out, data_out}), 80'd0);
    src_en = 2'b00;
    run(2);
    for (int n = 0; n < 2; n++) begin
      bwp[n] = brp[n];
      dwp[n] = drp[n];
    end
    @(negedge clk);
    reset_ = 1'b0;
    gb = got_w.size();
    run(10);
    check_eq("t6 no out after reset", 80'(got_w.size() - gb), 80'd0);
    gb = got_w.size(); eb = exp_w.size();
    push_frame(0, 16'd8, 1, 3'd0, 1'b1);
    push_frame(1, 16'd16, 2, 3'd0, 1'b1);
    src_en = 2'b11;
    run(50);
    src_en = 2'b00;
    cmp_words("t6", gb, eb);

    check_eq("strobe/framing rules", 80'(viol), 80'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/g2x_rx_arb.md
G2X_RX_ARB -- requirements
Module: g2x_rx_arb

Interface
REQ-001 Parameter MAX_BCNT, default 16'd9600: largest legal frame byte count.
REQ-002 Parameter IFG_CYCLES, default 2: idle cycles inserted between granted frames (0..15).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_  input  1  reset; asynchronous, active-high.
REQ-005 src_en  input  2  per-source enable; bit n enables source n.
REQ-006 bcnt_empty  input  2  byte-count FIFO empty, one bit per source.
REQ-007 bcnt_in0, bcnt_in1  input  16 each  byte-count FIFO read data; valid the cycle after bcnt_re.
REQ-008 data_in0, data_in1  input  64 each  data FIFO read data; valid the cycle after data_re.
REQ-009 ctrl_in0, ctrl_in1  input  8 each  ctrl FIFO read data, aligned with data_inN.
REQ-010 bcnt_re  output  2  byte-count FIFO read strobe per source.
REQ-011 data_re  output  2  data/ctrl FIFO read strobe per source.
REQ-012 data_out  output  64  merged frame word.
REQ-013 ctrl_out  output  8  ctrl byte for data_out.
REQ-014 out_valid  output  1  data_out/ctrl_out valid.
REQ-015 out_sof, out_eof  output  1 each  first/last word of frame, qualified by out_valid.
REQ-016 out_lbytes  output  3  valid bytes in the eof word; 0 encodes 8.
REQ-017 out_src  output  1  source of the current word.
REQ-018 bcnt_err  output  1  one-cycle pulse on an illegal byte count.

Function
REQ-019 The FSM SHALL have states IDLE, BCNT, XFER, GAP.
REQ-020 In IDLE, with eligible source n (src_en[n] and !bcnt_empty[n]), the block SHALL assert bcnt_re[n] for one cycle and enter BCNT.
REQ-021 If both sources are eligible, the grant SHALL go to the source not served last; after reset, source 0 wins.
REQ-022 In BCNT, the block SHALL capture bcnt_inN and compute words = (bcnt+7)>>3 (14 bits); lbytes = bcnt[2:0].
REQ-023 If bcnt==0, the block SHALL pulse bcnt_err, read no data, and enter GAP.
REQ-024 If bcnt>MAX_BCNT, the block SHALL pulse bcnt_err and enter XFER in drop mode.
REQ-025 Otherwise, the block SHALL enter XFER in normal mode.
REQ-026 In XFER, the block SHALL assert data_re[grant] on exactly `words` consecutive cycles, then enter GAP.
REQ-027 Each data word SHALL appear on data_out/ctrl_out, registered, two cycles after its data_re.
REQ-028 In normal mode, out_valid SHALL be 1 for each word; out_sof SHALL be 1 on the first word, and out_eof plus out_lbytes on the last.
REQ-029 A one-word frame SHALL have out_sof and out_eof both 1.
REQ-030 In drop mode, the block SHALL still read all words from the FIFO to keep alignment, with out_valid, out_sof and out_eof held 0.
REQ-031 GAP SHALL last IFG_CYCLES cycles, or one cycle if IFG_CYCLES==0, then return to IDLE.
REQ-032 Deasserting src_en mid-frame SHALL NOT abort the frame; it affects only the next arbitration.
REQ-033 bcnt_re and data_re SHALL never be asserted for both sources in the same cycle, and never together.
REQ-034 When out_valid is 0, out_sof, out_eof and out_lbytes SHALL be 0, and data_out/ctrl_out SHALL hold their last value.

Reset
REQ-035 While reset_ is 1, all outputs SHALL be 0, the FSM SHALL be IDLE, and last-served SHALL be source 1, so source 0 wins first.
REQ-036 Reset mid-frame SHALL immediately drop bcnt_re/data_re and discard in-flight words; no out_valid SHALL appear after reset_ falls until a new grant.

Verification
REQ-037 Source 0 bcnt=64, 8 words, IFG=2 -> data_re[0] for 8 cycles; out_valid for 8 cycles starting 2 cycles after the first data_re; sof on word 1; eof on word 8; lbytes=0; out_src=0.
REQ-038 Both sources pending, bcnt 9 and 17 -> source 0 frame (2 words, lbytes=1), 2-cycle gap, then source 1 frame (3 words, lbytes=1), then source 0 again if pending.
REQ-039 bcnt=0 on source 1 -> bcnt_err pulses once; data_re stays 0; out_valid stays 0; next frame is served normally.
REQ-040 bcnt=9601 -> bcnt_err pulses; data_re is asserted for 1201 cycles; out_valid stays 0; the following legal frame's data matches its FIFO contents.
REQ-041 src_en[0] cleared during a source 0 frame -> frame completes with eof; source 0 is not granted again while its enable is 0.
REQ-042 reset_ asserted on word 3 of 8 -> all outputs 0 within the reset cycle; after release, the next grant goes to source 0 with a clean sof.
